// File: rtl/mc_ctrl_pkg.sv
// Shared types and constants for the multi-cycle MIPS main control.
// ALUOp codes are also consumed by the ALU-control decoder.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RCOMP  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_RTYPE = 3'b010;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU = 2'b00;
    localparam logic [1:0] PCSRC_OUT = 2'b01;
    localparam logic [1:0] PCSRC_JMP = 2'b10;

endpackage

// File: rtl/mc_ctrl_outdec.sv
// State to datapath strobe decode for the main control FSM.
// Option: MC_CTRL_JUMP_EN builds the JUMP state decode.
module mc_ctrl_outdec
    import mc_ctrl_pkg::*;
(
    input  logic [3:0] state,
    input  logic       mem_ready,
    output logic       pcwrite,
    output logic       pcwritecond,
    output logic       iord,
    output logic       memread,
    output logic       memwrite,
    output logic       memtoreg,
    output logic       irwrite,
    output logic       regwrite,
    output logic       regdst,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsource,
    output logic [2:0] aluop
);

    always_comb begin
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        iord        = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        memtoreg    = 1'b0;
        irwrite     = 1'b0;
        regwrite    = 1'b0;
        regdst      = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = SRCB_REG;
        pcsource    = PCSRC_ALU;
        aluop       = ALUOP_ADD;
        unique case (state)
            S_FETCH: begin
                memread = 1'b1;
                alusrcb = SRCB_FOUR;
                // IR and PC only capture once the fetch data is valid
                irwrite = mem_ready;
                pcwrite = mem_ready;
            end
            S_DECODE: begin
                alusrcb = SRCB_IMMSH;
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
            end
            S_MEMRD: begin
                memread = 1'b1;
                iord    = 1'b1;
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            S_MEMWR: begin
                memwrite = 1'b1;
                iord     = 1'b1;
            end
            S_EXEC: begin
                alusrca = 1'b1;
                aluop   = ALUOP_RTYPE;
            end
            S_RCOMP: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
            end
            S_BRANCH: begin
                alusrca     = 1'b1;
                aluop       = ALUOP_SUB;
                pcwritecond = 1'b1;
                pcsource    = PCSRC_OUT;
            end
`ifdef MC_CTRL_JUMP_EN
            S_JUMP: begin
                pcwrite  = 1'b1;
                pcsource = PCSRC_JMP;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS main control: sequencing, memory-wait timeout.
// Option: MC_CTRL_JUMP_EN enables the j instruction (JUMP state).
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [2:0] ALUOp,
    output logic       illegal,
    output logic       timeout,
    output logic [3:0] state_o
);

    localparam logic [3:0] WAIT_MAX = 4'(MEM_WAIT_MAX);

    state_t     state, state_nxt;
    logic [3:0] wcnt;
    logic       tmo_q;
    logic       abort;
    logic       ill_dec;
    logic       stuck;

    logic       d_pcw, d_pcwc, d_iord, d_mrd, d_mwr;
    logic       d_m2r, d_irw, d_rgw, d_rdst, d_asa;
    logic [1:0] d_asb, d_psrc;
    logic [2:0] d_aop;

    assign stuck = !mem_ready && (wcnt == WAIT_MAX);

    always_comb begin
        state_nxt = state;
        abort     = 1'b0;
        ill_dec   = 1'b0;
        unique case (state)
            S_FETCH: begin
                if (mem_ready) state_nxt = S_DECODE;
                else           abort     = stuck;
            end
            S_DECODE: begin
                unique case (opcode)
                    OP_RTYPE:     state_nxt = S_EXEC;
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_BEQ:       state_nxt = S_BRANCH;
`ifdef MC_CTRL_JUMP_EN
                    OP_J:         state_nxt = S_JUMP;
`endif
                    default: begin
                        state_nxt = S_FETCH;
                        ill_dec   = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                state_nxt = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                if (mem_ready) state_nxt = S_MEMWB;
                else           abort     = stuck;
            end
            S_MEMWR: begin
                if (mem_ready) state_nxt = S_FETCH;
                else           abort     = stuck;
            end
            S_MEMWB:  state_nxt = S_FETCH;
            S_EXEC:   state_nxt = S_RCOMP;
            S_RCOMP:  state_nxt = S_FETCH;
            S_BRANCH: state_nxt = S_FETCH;
`ifdef MC_CTRL_JUMP_EN
            S_JUMP:   state_nxt = S_FETCH;
`endif
            default:  state_nxt = S_FETCH;
        endcase
        if (abort) state_nxt = S_FETCH;
    end

    // Only the memory states can hold, so "no change" means a wait cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
            wcnt  <= 4'd0;
            tmo_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (abort || state_nxt != state) wcnt <= 4'd0;
            else                             wcnt <= wcnt + 4'd1;
            if (abort) tmo_q <= 1'b1;
        end
    end

    mc_ctrl_outdec u_outdec (
        .state       (state),
        .mem_ready   (mem_ready),
        .pcwrite     (d_pcw),
        .pcwritecond (d_pcwc),
        .iord        (d_iord),
        .memread     (d_mrd),
        .memwrite    (d_mwr),
        .memtoreg    (d_m2r),
        .irwrite     (d_irw),
        .regwrite    (d_rgw),
        .regdst      (d_rdst),
        .alusrca     (d_asa),
        .alusrcb     (d_asb),
        .pcsource    (d_psrc),
        .aluop       (d_aop)
    );

    // Reset blanks every output in the reset cycle itself
    assign PCWrite     = d_pcw  & ~rst;
    assign PCWriteCond = d_pcwc & ~rst;
    assign IorD        = d_iord & ~rst;
    assign MemRead     = d_mrd  & ~rst;
    assign MemWrite    = d_mwr  & ~rst;
    assign MemtoReg    = d_m2r  & ~rst;
    assign IRWrite     = d_irw  & ~rst;
    assign RegWrite    = d_rgw  & ~rst;
    assign RegDst      = d_rdst & ~rst;
    assign ALUSrcA     = d_asa  & ~rst;
    assign ALUSrcB     = d_asb  & {2{~rst}};
    assign PCSource    = d_psrc & {2{~rst}};
    assign ALUOp       = d_aop  & {3{~rst}};
    assign illegal     = ill_dec & ~rst;
    assign timeout     = tmo_q   & ~rst;
    assign state_o     = rst ? 4'd0 : state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: instruction-level model
// expands each instruction into expected per-cycle outputs.
module tb_mc_control_fsm;

    localparam int WMAX = 3;
    localparam int F  = 0, D  = 1, MA = 2, MR = 3, WB = 4;
    localparam int MW = 5, EX = 6, RC = 7, BR = 8, JP = 9;
`ifdef MC_CTRL_JUMP_EN
    localparam bit J_EN = 1'b1;
`else
    localparam bit J_EN = 1'b0;
`endif

    localparam logic [5:0] RT = 6'b000000;
    localparam logic [5:0] LW = 6'b100011;
    localparam logic [5:0] SW = 6'b101011;
    localparam logic [5:0] BQ = 6'b000100;
    localparam logic [5:0] JJ = 6'b000010;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = '0;
    logic       mem_ready = 1'b0;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite;
    logic       MemtoReg, IRWrite, RegWrite, RegDst, ALUSrcA;
    logic [1:0] ALUSrcB, PCSource;
    logic [2:0] ALUOp;
    logic       illegal, timeout;
    logic [3:0] state_o;

    always #5 clk = ~clk;

    mc_control_fsm #(.MEM_WAIT_MAX(WMAX)) dut (
        .clk(clk), .rst(rst), .opcode(opcode),
        .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemtoReg(MemtoReg), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .RegDst(RegDst),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .PCSource(PCSource), .ALUOp(ALUOp),
        .illegal(illegal), .timeout(timeout),
        .state_o(state_o)
    );

    typedef struct packed {
        logic [3:0] st;
        logic pcw, pcwc, iord, mrd, mwr, m2r, irw, rgw, rdst, asa;
        logic [1:0] asb;
        logic [1:0] psrc;
        logic [2:0] aop;
        logic ill, tmo;
    } exp_t;

    typedef struct {
        bit         r;
        logic [5:0] op;
        bit         rdy;
        exp_t       e;
    } cyc_t;

    exp_t sbq[$];
    cyc_t iq[$];
    int   checks = 0;
    int   failures = 0;
    bit   tf = 1'b0;

    function automatic exp_t outs(int s, bit rdy, bit ill, bit tmo);
        exp_t e = '0;
        e.st  = 4'(s);
        e.ill = ill;
        e.tmo = tmo;
        case (s)
            F:  begin e.mrd = 1; e.asb = 2'b01; e.irw = rdy; e.pcw = rdy; end
            D:  e.asb = 2'b11;
            MA: begin e.asa = 1; e.asb = 2'b10; end
            MR: begin e.mrd = 1; e.iord = 1; end
            WB: begin e.rgw = 1; e.m2r = 1; end
            MW: begin e.mwr = 1; e.iord = 1; end
            EX: begin e.asa = 1; e.aop = 3'b010; end
            RC: begin e.rgw = 1; e.rdst = 1; end
            BR: begin
                e.asa = 1; e.aop = 3'b001;
                e.pcwc = 1; e.psrc = 2'b01;
            end
            JP: begin e.pcw = 1; e.psrc = 2'b10; end
            default: ;
        endcase
        return e;
    endfunction

    function automatic logic [5:0] rop();
        return 6'($urandom);
    endfunction

    function automatic bit rbit();
        return 1'($urandom);
    endfunction

    function automatic bit legal(logic [5:0] op);
        return op == RT || op == LW || op == SW || op == BQ ||
               (J_EN && op == JJ);
    endfunction

    function automatic void add(int s, bit rdy, logic [5:0] op, bit ill);
        cyc_t c;
        c.r   = 1'b0;
        c.op  = op;
        c.rdy = rdy;
        c.e   = outs(s, rdy, ill, tf);
        iq.push_back(c);
    endfunction

    // A memory phase: `stall` not-ready cycles then ready, or an
    // abort after WMAX+1 not-ready cycles when stall exceeds WMAX.
    function automatic bit mem(int s, int stall);
        if (stall > WMAX) begin
            for (int k = 0; k <= WMAX; k++) add(s, 1'b0, rop(), 1'b0);
            tf = 1'b1;
            return 1'b1;
        end
        for (int k = 0; k < stall; k++) add(s, 1'b0, rop(), 1'b0);
        add(s, 1'b1, rop(), 1'b0);
        return 1'b0;
    endfunction

    function automatic void build(logic [5:0] op, int fs, int ms);
        bit ab;
        iq.delete();
        while (mem(F, fs)) fs = $urandom_range(0, WMAX);
        add(D, rbit(), op, !legal(op));
        if (!legal(op)) return;
        case (op)
            RT: begin
                add(EX, rbit(), rop(), 1'b0);
                add(RC, rbit(), rop(), 1'b0);
            end
            LW: begin
                add(MA, rbit(), op, 1'b0);
                ab = mem(MR, ms);
                if (!ab) add(WB, rbit(), rop(), 1'b0);
            end
            SW: begin
                add(MA, rbit(), op, 1'b0);
                ab = mem(MW, ms);
            end
            BQ: add(BR, rbit(), rop(), 1'b0);
            default: add(JP, rbit(), rop(), 1'b0);
        endcase
    endfunction

    task automatic drive(input cyc_t c);
        @(posedge clk);
        #1;
        rst       = c.r;
        opcode    = c.op;
        mem_ready = c.rdy;
        sbq.push_back(c.e);
    endtask

    task automatic drive_rst();
        cyc_t c;
        c.r   = 1'b1;
        c.op  = rop();
        c.rdy = rbit();
        c.e   = '0;
        drive(c);
    endtask

    task automatic run(input logic [5:0] op, input int fs,
                       input int ms, input int cut);
        build(op, fs, ms);
        for (int i = 0; i < iq.size(); i++) begin
            if (i == cut) begin
                drive_rst();
                tf = 1'b0;
                return;
            end
            drive(iq[i]);
        end
    endtask

    initial begin : monitor
        exp_t e;
        exp_t a;
        int   n;
        n = 0;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                a = {state_o, PCWrite, PCWriteCond, IorD, MemRead,
                     MemWrite, MemtoReg, IRWrite, RegWrite, RegDst,
                     ALUSrcA, ALUSrcB, PCSource, ALUOp, illegal,
                     timeout};
                checks++;
                if (a !== e) begin
                    failures++;
                    $display("FAIL cycle%0d got=%06h st=%0d exp=%06h st=%0d",
                             n, a, a.st, e, e.st);
                end
                n++;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: time limit reached, queue=%0d",
                 sbq.size());
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int k;
        int fs;
        int ms;
        int cut;
        logic [5:0] op;
        repeat (3) drive_rst();
        run(RT, 0, 0, -1);
        run(LW, 0, 2, -1);
        run(SW, 0, 0, -1);
        run(BQ, 0, 0, -1);
        run(6'h3f, 0, 0, -1);
        run(JJ, 0, 0, -1);
        run(SW, 0, WMAX + 1, -1);
        run(LW, 1, WMAX, -1);
        run(RT, WMAX + 1, 0, -1);
        run(RT, 0, 0, 2);
        run(LW, 0, WMAX + 1, 4);
        run(BQ, WMAX, 0, -1);
        for (int i = 0; i < 400; i++) begin
            k = $urandom % 7;
            case (k)
                0: op = RT;
                1: op = LW;
                2: op = SW;
                3: op = BQ;
                4: op = JJ;
                default: op = rop();
            endcase
            fs  = ($urandom % 4 == 0) ? $urandom_range(1, WMAX + 1) : 0;
            ms  = ($urandom % 4 == 0) ? $urandom_range(1, WMAX + 1) : 0;
            cut = ($urandom % 12 == 0) ? $urandom_range(0, 7) : -1;
            run(op, fs, ms, cut);
        end
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending, exp 0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
